// File: rtl/fetch_pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit_if
//  Description : Bundle of the fetch unit's non-clock signals. It carries the
//                redirect and stall inputs from downstream, the
//                instruction-memory request/ack channel, and the IF/ID output
//                bundle.
//  Modports    : master - the fetch unit itself
//                slave  - the environment (imem, decode, branch logic)
//  Signals     : redirect_valid/redirect_pc  taken-branch redirect
//                stall                       IF/ID cannot accept
//                imem_req/imem_addr          fetch request, word aligned
//                imem_ack/imem_rdata         request completion + data
//                if_valid/if_inst/if_pc/if_pc4  IF/ID boundary
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_pc_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    input  redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4
  );

  modport slave (
    output redirect_valid, redirect_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_inst, if_pc, if_pc4
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_unit
//  Description : Fetch-stage PC owner. It issues one instruction-memory
//                request at a time and presents fetched words to IF/ID. A
//                one-entry skid buffer catches a word that returns while
//                decode is stalled. Redirects squash wrong-path fetches and
//                restart fetching at the target.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                bus    - fetch_pc_unit_if.master (redirect, stall, imem
//                         channel, IF/ID outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_WAIT_SKID = 2'd2,
    S_DRAIN     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        advance;
  logic [31:0] redirect_target;

  // Output register may take new data when empty or when decode consumes it.
  assign advance         = !out_valid_q || !bus.stall;
  assign redirect_target = bus.redirect_pc & ~32'h3;

  // Request channel depends only on registered state, never on inputs.
  assign bus.imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  assign bus.if_valid = out_valid_q;
  assign bus.if_inst  = out_inst_q;
  assign bus.if_pc    = out_pc_q;
  assign bus.if_pc4   = out_pc_q + PC_INC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'h0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= 32'h0;
      out_pc_q     <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 32'h0;
      skid_pc_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;

    if (bus.redirect_valid) begin
      // Redirect overrides stall: everything already fetched is wrong-path.
      pc_d         = redirect_target;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ack) begin
            state_d = S_FETCH;
          end else begin
            // Keep the old request on the bus until memory completes it.
            state_d      = S_DRAIN;
            drain_addr_d = pc_q;
          end
        end
        S_DRAIN: state_d = S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end else begin
      // Decode consumed the current word; refilled below if data is ready.
      if (advance) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (bus.imem_ack) begin
            pc_d = pc_q + PC_INC;
            if (advance) begin
              out_valid_d = 1'b1;
              out_inst_d  = bus.imem_rdata;
              out_pc_d    = pc_q;
            end else begin
              skid_valid_d = 1'b1;
              skid_inst_d  = bus.imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = S_WAIT_SKID;
            end
          end
        end
        S_WAIT_SKID: begin
          if (advance) begin
            out_valid_d  = 1'b1;
            out_inst_d   = skid_inst_q;
            out_pc_d     = skid_pc_q;
            skid_valid_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
        S_DRAIN: begin
          // Stale-address data is dropped; fetch resumes at the new pc.
          if (bus.imem_ack) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
